// File: rtl/overdrive_pkg.sv
// Shared types and helpers for the overdrive/clipper pipeline.
// Wide intermediate math is done at OD_WIDE_W bits and narrowed with sat_signed().
package overdrive_pkg;

   typedef enum logic [1:0] {
      OD_BYPASS = 2'd0,
      OD_HARD   = 2'd1,
      OD_SOFT   = 2'd2,
      OD_ASYM   = 2'd3
   } od_mode_e;

   localparam int OD_WIDE_W      = 64;
   localparam int OD_LEVEL_MAX_W = 16;

   // Per-sample configuration that travels down the pipe with its sample.
   typedef struct packed {
      od_mode_e                  mode;
      logic [OD_LEVEL_MAX_W-1:0] level;
   } od_ctrl_t;

   function automatic logic signed [OD_WIDE_W-1:0] sat_signed(
      input logic signed [OD_WIDE_W-1:0] v,
      input int                          w
   );
      logic signed [OD_WIDE_W-1:0] hi;
      logic signed [OD_WIDE_W-1:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (v > hi) begin
         return hi;
      end else if (v < lo) begin
         return lo;
      end
      return v;
   endfunction

endpackage

// File: rtl/overdrive_pipe_curve.sv
// Combinational transfer curve for the last pipeline stage: curve select,
// clamping and the extra clip condition of the asymmetric curve.
module od_curve
   import overdrive_pkg::*;
#(
   parameter int DATA_W    = 24,
   parameter int FRAC_BITS = 12
) (
   input  logic [1:0]        mode,
   input  logic [DATA_W-1:0] xg,
   input  logic [DATA_W-1:0] x3,
   input  logic [DATA_W+1:0] t,
   input  logic              clip_in,
   output logic [DATA_W-1:0] y,
   output logic              clip_out
);

   localparam logic signed [DATA_W-1:0] L_POS      = DATA_W'(1 << FRAC_BITS);
   localparam logic signed [DATA_W-1:0] L_NEG      = -L_POS;
   localparam logic signed [DATA_W-1:0] L_HALF_NEG = -(L_POS >>> 1);

   od_mode_e                    mode_e;
   logic signed [DATA_W-1:0]    xg_s;
   logic signed [DATA_W-1:0]    x3_s;
   logic signed [DATA_W+1:0]    t_s;
   logic signed [OD_WIDE_W-1:0] soft_wide;
   logic signed [DATA_W-1:0]    soft_y;
   logic signed [DATA_W-1:0]    y_s;

   assign mode_e    = od_mode_e'(mode);
   assign xg_s      = $signed(xg);
   assign x3_s      = $signed(x3);
   assign t_s       = $signed(t);
   assign soft_wide = OD_WIDE_W'(t_s) - OD_WIDE_W'(x3_s);

   // Cubic is only valid inside (-L, L); outside it the curve is pinned to +/-L.
   always_comb begin
      soft_y = DATA_W'(soft_wide >>> 1);
      if (xg_s >= L_POS) begin
         soft_y = L_POS;
      end else if (xg_s <= L_NEG) begin
         soft_y = L_NEG;
      end
   end

   always_comb begin
      y_s      = xg_s;
      clip_out = clip_in;
      case (mode_e)
         OD_BYPASS: begin
            y_s      = xg_s;
            clip_out = 1'b0;
         end
         OD_HARD: begin
            if (xg_s >= L_POS) begin
               y_s = L_POS;
            end else if (xg_s <= L_NEG) begin
               y_s = L_NEG;
            end
         end
         OD_SOFT: begin
            y_s = soft_y;
         end
         OD_ASYM: begin
            if (!xg_s[DATA_W-1]) begin
               y_s = soft_y;
            end else if (xg_s <= L_HALF_NEG) begin
               y_s      = L_HALF_NEG;
               clip_out = 1'b1;
            end
         end
         default: begin
            y_s = xg_s;
         end
      endcase
   end

   assign y = y_s;

endmodule

// File: rtl/overdrive_pipe.sv
// Four-stage overdrive/clipper on a valid/ready stream with a saturating
// clip counter. Config is captured per sample and travels with it.
module overdrive_pipe
   import overdrive_pkg::*;
#(
   parameter int DATA_W    = 24,
   parameter int FRAC_BITS = 12,
   parameter int GAIN_W    = 8,
   parameter int LEVEL_W   = 8,
   parameter int CNT_W     = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               s_valid,
   output logic               s_ready,
   input  logic [DATA_W-1:0]  s_data,
   input  logic [1:0]         cfg_mode,
   input  logic [GAIN_W-1:0]  cfg_gain,
   input  logic [LEVEL_W-1:0] cfg_level,
   output logic               m_valid,
   input  logic               m_ready,
   output logic [DATA_W-1:0]  m_data,
   output logic               m_clip,
   input  logic               clip_clear,
   output logic [CNT_W-1:0]   clip_count
);

   localparam int GAIN_FRAC = 4;
   localparam int T_W       = DATA_W + 2;

   localparam logic signed [DATA_W-1:0] L_POS = DATA_W'(1 << FRAC_BITS);
   localparam logic signed [DATA_W-1:0] L_NEG = -L_POS;

   logic en;

   logic                     v1_q, v1_d;
   logic signed [DATA_W-1:0] xg1_q, xg1_d;
   od_ctrl_t                 ctrl1_q, ctrl1_d;

   logic                     v2_q, v2_d;
   logic signed [DATA_W-1:0] xg2_q, xg2_d;
   logic signed [DATA_W-1:0] x2_q, x2_d;
   logic                     clip2_q, clip2_d;
   od_ctrl_t                 ctrl2_q, ctrl2_d;

   logic                     v3_q, v3_d;
   logic signed [DATA_W-1:0] xg3_q, xg3_d;
   logic signed [DATA_W-1:0] x3_q, x3_d;
   logic signed [T_W-1:0]    t3_q, t3_d;
   logic                     clip3_q, clip3_d;
   od_ctrl_t                 ctrl3_q, ctrl3_d;

   logic                     m_valid_q, m_valid_d;
   logic [DATA_W-1:0]        m_data_q, m_data_d;
   logic                     m_clip_q, m_clip_d;
   logic [CNT_W-1:0]         clip_count_q, clip_count_d;

   logic signed [OD_WIDE_W-1:0] in_prod;
   logic signed [OD_WIDE_W-1:0] sq_prod;
   logic signed [OD_WIDE_W-1:0] cube_prod;
   logic signed [OD_WIDE_W-1:0] t_wide;
   logic signed [OD_WIDE_W-1:0] out_prod;

   logic [DATA_W-1:0]        curve_y;
   logic                     curve_clip;

   od_curve #(
      .DATA_W    (DATA_W),
      .FRAC_BITS (FRAC_BITS)
   ) u_curve (
      .mode     (ctrl3_q.mode),
      .xg       (xg3_q),
      .x3       (x3_q),
      .t        (t3_q),
      .clip_in  (clip3_q),
      .y        (curve_y),
      .clip_out (curve_clip)
   );

   // All products are formed at full width so no intermediate ever wraps.
   assign in_prod   = OD_WIDE_W'($signed(s_data)) * OD_WIDE_W'($signed({1'b0, cfg_gain}));
   assign sq_prod   = OD_WIDE_W'(xg1_q) * OD_WIDE_W'(xg1_q);
   assign cube_prod = OD_WIDE_W'(x2_q) * OD_WIDE_W'(xg2_q);
   assign t_wide    = OD_WIDE_W'(xg2_q) * 64'sd3;
   assign out_prod  = OD_WIDE_W'($signed(curve_y)) * OD_WIDE_W'($signed({1'b0, ctrl3_q.level}));

   always_comb begin
      en        = !m_valid_q || m_ready;

      v1_d      = v1_q;
      xg1_d     = xg1_q;
      ctrl1_d   = ctrl1_q;
      v2_d      = v2_q;
      xg2_d     = xg2_q;
      x2_d      = x2_q;
      clip2_d   = clip2_q;
      ctrl2_d   = ctrl2_q;
      v3_d      = v3_q;
      xg3_d     = xg3_q;
      x3_d      = x3_q;
      t3_d      = t3_q;
      clip3_d   = clip3_q;
      ctrl3_d   = ctrl3_q;
      m_valid_d = m_valid_q;
      m_data_d  = m_data_q;
      m_clip_d  = m_clip_q;

      if (en) begin
         v1_d = s_valid;
         if (s_valid) begin
            xg1_d         = DATA_W'(sat_signed(in_prod >>> GAIN_FRAC, DATA_W));
            ctrl1_d.mode  = od_mode_e'(cfg_mode);
            ctrl1_d.level = OD_LEVEL_MAX_W'(cfg_level);
         end

         v2_d = v1_q;
         if (v1_q) begin
            xg2_d   = xg1_q;
            x2_d    = DATA_W'(sq_prod >>> FRAC_BITS);
            clip2_d = (ctrl1_q.mode != OD_BYPASS) && ((xg1_q >= L_POS) || (xg1_q <= L_NEG));
            ctrl2_d = ctrl1_q;
         end

         v3_d = v2_q;
         if (v2_q) begin
            xg3_d   = xg2_q;
            x3_d    = DATA_W'(cube_prod >>> FRAC_BITS);
            t3_d    = T_W'(t_wide);
            clip3_d = clip2_q;
            ctrl3_d = ctrl2_q;
         end

         m_valid_d = v3_q;
         if (v3_q) begin
            m_data_d = DATA_W'(sat_signed(out_prod >>> (LEVEL_W - 1), DATA_W));
            m_clip_d = curve_clip;
         end
      end
   end

   always_comb begin
      clip_count_d = clip_count_q;
      if (clip_clear) begin
         clip_count_d = '0;
      end else if (m_valid_q && m_ready && m_clip_q && (clip_count_q != '1)) begin
         clip_count_d = clip_count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q         <= 1'b0;
         xg1_q        <= '0;
         ctrl1_q      <= '0;
         v2_q         <= 1'b0;
         xg2_q        <= '0;
         x2_q         <= '0;
         clip2_q      <= 1'b0;
         ctrl2_q      <= '0;
         v3_q         <= 1'b0;
         xg3_q        <= '0;
         x3_q         <= '0;
         t3_q         <= '0;
         clip3_q      <= 1'b0;
         ctrl3_q      <= '0;
         m_valid_q    <= 1'b0;
         m_data_q     <= '0;
         m_clip_q     <= 1'b0;
         clip_count_q <= '0;
      end else begin
         v1_q         <= v1_d;
         xg1_q        <= xg1_d;
         ctrl1_q      <= ctrl1_d;
         v2_q         <= v2_d;
         xg2_q        <= xg2_d;
         x2_q         <= x2_d;
         clip2_q      <= clip2_d;
         ctrl2_q      <= ctrl2_d;
         v3_q         <= v3_d;
         xg3_q        <= xg3_d;
         x3_q         <= x3_d;
         t3_q         <= t3_d;
         clip3_q      <= clip3_d;
         ctrl3_q      <= ctrl3_d;
         m_valid_q    <= m_valid_d;
         m_data_q     <= m_data_d;
         m_clip_q     <= m_clip_d;
         clip_count_q <= clip_count_d;
      end
   end

   assign s_ready    = en;
   assign m_valid    = m_valid_q;
   assign m_data     = m_data_q;
   assign m_clip     = m_clip_q;
   assign clip_count = clip_count_q;

endmodule

// File: tb/tb_overdrive_pipe.sv
// Directed bench for overdrive_pipe: single-sample vector table, then
// backpressure, clip counter and mid-stream reset sequences.
module tb_overdrive_pipe;

   localparam int DATA_W  = 24;
   localparam int GAIN_W  = 8;
   localparam int LEVEL_W = 8;
   localparam int CNT_W   = 16;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               s_valid;
   logic               s_ready;
   logic [DATA_W-1:0]  s_data;
   logic [1:0]         cfg_mode;
   logic [GAIN_W-1:0]  cfg_gain;
   logic [LEVEL_W-1:0] cfg_level;
   logic               m_valid;
   logic               m_ready;
   logic [DATA_W-1:0]  m_data;
   logic               m_clip;
   logic               clip_clear;
   logic [CNT_W-1:0]   clip_count;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   overdrive_pipe #(
      .DATA_W    (DATA_W),
      .FRAC_BITS (12),
      .GAIN_W    (GAIN_W),
      .LEVEL_W   (LEVEL_W),
      .CNT_W     (CNT_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .s_data     (s_data),
      .cfg_mode   (cfg_mode),
      .cfg_gain   (cfg_gain),
      .cfg_level  (cfg_level),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_data     (m_data),
      .m_clip     (m_clip),
      .clip_clear (clip_clear),
      .clip_count (clip_count)
   );

   typedef struct {
      logic [1:0] mode;
      logic [7:0] gain;
      logic [7:0] level;
      int         din;
      int         exp_data;
      logic       exp_clip;
      string      name;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: actual %0d required %0d", name, act, exp);
      end
   endtask

   task automatic add_vec(input logic [1:0] mode, input logic [7:0] gain, input logic [7:0] level,
                          input int din, input int exp_data, input logic exp_clip, input string name);
      vec_t v;
      v.mode = mode; v.gain = gain; v.level = level;
      v.din = din; v.exp_data = exp_data; v.exp_clip = exp_clip; v.name = name;
      vecs.push_back(v);
   endtask

   task automatic drive_sample(input logic [1:0] mode, input logic [7:0] gain,
                               input logic [7:0] level, input int din);
      s_valid   = 1'b1;
      s_data    = din[DATA_W-1:0];
      cfg_mode  = mode;
      cfg_gain  = gain;
      cfg_level = level;
   endtask

   // One isolated sample: accepted on edge E, must appear after edge E+3, not before.
   task automatic run_vec(input vec_t v);
      @(negedge clk);
      m_ready = 1'b1;
      drive_sample(v.mode, v.gain, v.level, v.din);
      @(posedge clk);
      @(negedge clk);
      s_valid   = 1'b0;
      cfg_mode  = 2'd0;
      cfg_gain  = 8'h00;
      cfg_level = 8'h00;
      s_data    = '0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      chk({v.name, "_early_valid"}, m_valid, 0);
      @(posedge clk);
      @(negedge clk);
      chk({v.name, "_valid"}, m_valid, 1);
      chk({v.name, "_data"}, $signed(m_data), v.exp_data);
      chk({v.name, "_clip"}, m_clip, v.exp_clip);
   endtask

   int          bp_din  [8] = '{100, -200, 5000, -300, 2048, -2048, -3000, 7};
   logic [1:0]  bp_mode [8] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd0};
   int          bp_exp  [8] = '{100, -200, 4096, -300, 2816, -2816, -2048, 7};
   logic        bp_clip [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

   initial begin
      int   in_idx;
      int   out_idx;
      logic prev_stall;
      logic [DATA_W-1:0] prev_data;
      logic prev_clip;
      logic saw_stall;
      logic seen;

      rst_n = 1'b0; s_valid = 1'b0; s_data = '0; cfg_mode = 2'd0;
      cfg_gain = 8'h10; cfg_level = 8'h80; m_ready = 1'b1; clip_clear = 1'b0;

      //            mode  gain   level  din       expect    clip
      add_vec(2'd2, 8'h10, 8'h80,  2048,     2816,    1'b0, "soft_pos");
      add_vec(2'd2, 8'h10, 8'h80, -2048,    -2816,    1'b0, "soft_neg");
      add_vec(2'd2, 8'h10, 8'h80,  4096,     4096,    1'b1, "soft_at_L");
      add_vec(2'd1, 8'h10, 8'h80,  5000,     4096,    1'b1, "hard_pos");
      add_vec(2'd1, 8'h10, 8'h80, -5000,    -4096,    1'b1, "hard_neg");
      add_vec(2'd1, 8'h10, 8'h80,  1000,     1000,    1'b0, "hard_lin");
      add_vec(2'd0, 8'h10, 8'h80,  5000,     5000,    1'b0, "bypass");
      add_vec(2'd2, 8'h20, 8'h80,  1024,     2816,    1'b0, "soft_gain2");
      add_vec(2'd2, 8'h10, 8'h40,  2048,     1408,    1'b0, "soft_level_half");
      add_vec(2'd2, 8'hFF, 8'h80,  8388607,  4096,    1'b1, "soft_gain_sat");
      add_vec(2'd3, 8'h10, 8'h80,  3000,     3695,    1'b0, "asym_pos");
      add_vec(2'd3, 8'h10, 8'h80, -1000,    -1000,    1'b0, "asym_neg_lin");
      add_vec(2'd3, 8'h10, 8'h80, -3000,    -2048,    1'b1, "asym_neg_clip");
      add_vec(2'd3, 8'h10, 8'h80, -2048,    -2048,    1'b1, "asym_half_L");
      add_vec(2'd3, 8'h10, 8'h80,  5000,     4096,    1'b1, "asym_pos_clip");
      add_vec(2'd3, 8'h10, 8'h80, -8000,    -2048,    1'b1, "asym_deep_neg");
      add_vec(2'd1, 8'h10, 8'h80,  4095,     4095,    1'b0, "hard_below_L");
      add_vec(2'd1, 8'h10, 8'h80, -4096,    -4096,    1'b1, "hard_at_negL");
      add_vec(2'd2, 8'h10, 8'h80, -3000,    -3695,    1'b0, "soft_neg_floor");
      add_vec(2'd2, 8'h10, 8'h80, -1,       -2,       1'b0, "soft_minus1");
      add_vec(2'd0, 8'h10, 8'h40, -3,       -2,       1'b0, "level_floor");
      add_vec(2'd0, 8'h08, 8'h80, -1,       -1,       1'b0, "gain_floor");
      add_vec(2'd0, 8'h10, 8'hFF,  8388607,  8388607, 1'b0, "out_sat_pos");
      add_vec(2'd0, 8'h10, 8'hFF, -8388608, -8388608, 1'b0, "out_sat_neg");
      add_vec(2'd0, 8'hFF, 8'h80, -8388608, -8388608, 1'b0, "gain_sat_neg");
      add_vec(2'd2, 8'h10, 8'h00,  2048,     0,       1'b0, "level_zero");

      #12;
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_data", $signed(m_data), 0);
      chk("rst_m_clip", m_clip, 0);
      chk("rst_clip_count", clip_count, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_s_ready", s_ready, 1);

      for (int i = 0; i < vecs.size(); i++) begin
         run_vec(vecs[i]);
      end

      // Backpressure stream with per-sample mode changes.
      @(negedge clk);
      s_valid = 1'b0;
      m_ready = 1'b1;
      @(negedge clk);
      in_idx = 0; out_idx = 0; prev_stall = 1'b0; prev_data = '0; prev_clip = 1'b0; saw_stall = 1'b0;
      for (int cyc = 0; cyc < 40 && out_idx < 8; cyc++) begin
         if (cyc > 0) @(negedge clk);
         m_ready = !(cyc >= 5 && cyc <= 7);
         if (in_idx < 8) drive_sample(bp_mode[in_idx], 8'h10, 8'h80, bp_din[in_idx]);
         else s_valid = 1'b0;
         #1;
         if (prev_stall) begin
            chk("bp_hold_data", m_data, prev_data);
            chk("bp_hold_clip", m_clip, prev_clip);
         end
         if (m_valid && !m_ready) begin
            chk("bp_s_ready_low", s_ready, 0);
            saw_stall = 1'b1;
         end
         if (m_valid && m_ready) begin
            chk("bp_data", $signed(m_data), bp_exp[out_idx]);
            chk("bp_clip", m_clip, bp_clip[out_idx]);
            out_idx++;
         end
         prev_stall = m_valid && !m_ready;
         prev_data  = m_data;
         prev_clip  = m_clip;
         if (s_valid && s_ready) in_idx++;
      end
      s_valid = 1'b0;
      m_ready = 1'b1;
      chk("bp_delivered", out_idx, 8);
      chk("bp_stall_seen", saw_stall, 1);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("bp_no_dup", m_valid, 0);
      end

      // Clip counter: 10 clipped beats back to back.
      @(negedge clk);
      clip_clear = 1'b1;
      @(negedge clk);
      clip_clear = 1'b0;
      chk("cnt_cleared", clip_count, 0);
      for (int k = 0; k < 10; k++) begin
         drive_sample(2'd1, 8'h10, 8'h80, 5000);
         @(negedge clk);
      end
      s_valid = 1'b0;
      drive_sample(2'd1, 8'h10, 8'h80, 1000);
      @(negedge clk);
      s_valid = 1'b0;
      repeat (6) @(negedge clk);
      chk("cnt_ten", clip_count, 10);

      // Clear in the same cycle as a delivered clip beat: clear wins.
      drive_sample(2'd1, 8'h10, 8'h80, -5000);
      @(negedge clk);
      s_valid = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
         #1;
         if (m_valid) seen = 1'b1;
         else @(negedge clk);
      end
      chk("cnt_beat_seen", seen, 1);
      chk("cnt_beat_clip", m_clip, 1);
      clip_clear = 1'b1;
      @(negedge clk);
      clip_clear = 1'b0;
      chk("cnt_clear_wins", clip_count, 0);
      drive_sample(2'd3, 8'h10, 8'h80, -3000);
      @(negedge clk);
      s_valid = 1'b0;
      repeat (5) @(negedge clk);
      chk("cnt_after_clear", clip_count, 1);

      // Reset in the middle of a stream of clipped samples.
      for (int k = 0; k < 5; k++) begin
         drive_sample(2'd1, 8'h10, 8'h80, 6000);
         @(negedge clk);
      end
      #1;
      chk("mid_pre_valid", m_valid, 1);
      chk("mid_pre_count", clip_count, 2);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", m_valid, 0);
      chk("mid_rst_count", clip_count, 0);
      chk("mid_rst_data", $signed(m_data), 0);
      s_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("mid_dropped", m_valid, 0);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
